// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the multi-channel memory port arbiter.
package mem_arb_pkg;

   // Arbitration modes
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Widest channel tag needed (up to 8 requesters)
   localparam int MAX_TAG_W = 3;

   // Channel tag width: clog2(num_ch), never below 1
   function automatic int tag_w(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

   // One slot of the read-tag shift pipeline
   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] tag;
   } rd_entry_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bus of the memory port arbiter.
// Handshake: a requester raises req_valid[i] with req_write/req_addr/req_wdata
// and holds those fields stable while req_valid[i] is high and req_ready[i] is
// low; the request transfers in the cycle both are high. rsp_valid is a
// one-cycle strobe with no backpressure and must be accepted when it appears.
interface mem_port_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [NUM_CH-1:0]        req_valid;
   logic [NUM_CH-1:0]        req_ready;
   logic [NUM_CH-1:0]        req_write;
   logic [NUM_CH*ADDR_W-1:0] req_addr;
   logic [NUM_CH*DATA_W-1:0] req_wdata;
   logic [NUM_CH-1:0]        rsp_valid;
   logic [DATA_W-1:0]        rsp_data;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// NUM_CH-wide single-grant arbiter: fixed priority (mode=0, channel 0 first)
// or round-robin (mode=1, search starts at the pointer and wraps).
module rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter  int NUM_CH = 2,
   localparam int TAG_W  = tag_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] grant,
   output logic              grant_any,
   output logic [TAG_W-1:0]  grant_idx
);

   logic [TAG_W-1:0] ptr;

   // Combinational search for the first requesting channel from the start point
   always_comb begin
      int               idx;
      logic [TAG_W-1:0] sel;
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      sel       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx = (mode ? int'(ptr) : 0) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         sel = TAG_W'(idx);
         if (!grant_any && req[sel]) begin
            grant[sel] = 1'b1;
            grant_any  = 1'b1;
            grant_idx  = sel;
         end
      end
   end

   // Round-robin pointer moves past the winner; holds when nothing is granted
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (grant_any && mode) begin
         ptr <= (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory port: arbitrates NUM_CH requesters, drives the registered
// memory port, tracks in-flight reads and routes read data to the issuer.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 16,
   parameter int RD_LATENCY = 1,
   parameter int ARB_MODE   = ARB_FIXED
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_port_arbiter_if.slave    req_if,
   output logic [ADDR_W-1:0]    address_to_memory,
   output logic [DATA_W-1:0]    data_to_memory,
   output logic                 data_to_memory_write_en,
   input  logic [DATA_W-1:0]    data_from_memory
);

   localparam int   TAG_W    = tag_w(NUM_CH);
   localparam int   DEPTH    = RD_LATENCY + 1;
   localparam logic MODE_BIT = 1'(ARB_MODE == ARB_RR);

   logic [NUM_CH-1:0] grant;
   logic              grant_any;
   logic [TAG_W-1:0]  grant_idx;

   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_write;

   rd_entry_t         rd_pipe [DEPTH];
   logic [NUM_CH-1:0] rsp_valid_q;
   logic [DATA_W-1:0] rsp_data_q;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .mode      (MODE_BIT),
      .req       (req_if.req_valid),
      .grant     (grant),
      .grant_any (grant_any),
      .grant_idx (grant_idx)
   );

   assign req_if.req_ready = grant;
   assign req_if.rsp_valid = rsp_valid_q;
   assign req_if.rsp_data  = rsp_data_q;

   // Pick the granted channel's request fields out of the packed buses
   always_comb begin
      sel_addr  = req_if.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      sel_wdata = req_if.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
      sel_write = req_if.req_write[grant_idx];
   end

   // Issue registers: load on grant, otherwise hold address/data and drop the strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         address_to_memory       <= '0;
         data_to_memory          <= '0;
         data_to_memory_write_en <= 1'b0;
      end else if (grant_any) begin
         address_to_memory       <= sel_addr;
         data_to_memory          <= sel_wdata;
         data_to_memory_write_en <= sel_write;
      end else begin
         data_to_memory_write_en <= 1'b0;
      end
   end

   // Read-tag pipeline: the last slot lines up with data_from_memory
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) rd_pipe[k] <= '0;
      end else begin
         rd_pipe[0] <= '{valid: grant_any & ~sel_write, tag: MAX_TAG_W'(grant_idx)};
         for (int k = 1; k < DEPTH; k++) rd_pipe[k] <= rd_pipe[k-1];
      end
   end

   // Response register: one-cycle strobe to the issuer, data held between responses
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= '0;
         if (rd_pipe[DEPTH-1].valid) begin
            rsp_valid_q <= NUM_CH'(1) << rd_pipe[DEPTH-1].tag;
            rsp_data_q  <= data_from_memory;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Two arbiter instances side by side: lane 0 is 2-channel fixed priority with
// read latency 1, lane 1 is 4-channel round-robin with read latency 3.
module tb_mem_port_arbiter;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic [1:0] rst = 2'b11;
   always #5 clk = ~clk;

   function automatic int nch(input int u);    return (u == 0) ? 2 : 4; endfunction
   function automatic int lat(input int u);    return (u == 0) ? 1 : 3; endfunction
   function automatic bit is_rr(input int u);  return (u == 1);         endfunction
   function automatic logic [15:0] init_val(input int a);
      return 16'((a * 3) ^ 16'hA5C3);
   endfunction

   // ---------------- stimulus-side signals ----------------
   logic [3:0]  vld [2];
   logic [3:0]  wr  [2];
   logic [15:0] addr [2][4];
   logic [15:0] wdat [2][4];

   // ---------------- DUT-side signals ----------------
   logic [3:0]  rdy [2];
   logic [3:0]  rspv [2];
   logic [15:0] rspd [2];
   logic [15:0] mpa [2];
   logic [15:0] mpd [2];
   logic        mwe [2];
   logic [15:0] maddr_a, maddr_b, mdata_a, mdata_b, mdin_a, mdin_b;
   logic        mwe_a, mwe_b;

   mem_port_arbiter_if #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16)) if_a ();
   mem_port_arbiter_if #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16)) if_b ();

   assign if_a.req_valid = vld[0][1:0];
   assign if_a.req_write = wr[0][1:0];
   assign if_a.req_addr  = {addr[0][1], addr[0][0]};
   assign if_a.req_wdata = {wdat[0][1], wdat[0][0]};
   assign if_b.req_valid = vld[1];
   assign if_b.req_write = wr[1];
   assign if_b.req_addr  = {addr[1][3], addr[1][2], addr[1][1], addr[1][0]};
   assign if_b.req_wdata = {wdat[1][3], wdat[1][2], wdat[1][1], wdat[1][0]};

   mem_port_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(1), .ARB_MODE(0)) dut_a (
      .clk (clk), .rst (rst[0]), .req_if (if_a),
      .address_to_memory (maddr_a), .data_to_memory (mdata_a),
      .data_to_memory_write_en (mwe_a), .data_from_memory (mdin_a)
   );

   mem_port_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(3), .ARB_MODE(1)) dut_b (
      .clk (clk), .rst (rst[1]), .req_if (if_b),
      .address_to_memory (maddr_b), .data_to_memory (mdata_b),
      .data_to_memory_write_en (mwe_b), .data_from_memory (mdin_b)
   );

   always_comb begin
      rdy[0]  = {2'b00, if_a.req_ready};
      rdy[1]  = if_b.req_ready;
      rspv[0] = {2'b00, if_a.rsp_valid};
      rspv[1] = if_b.rsp_valid;
      rspd[0] = if_a.rsp_data;
      rspd[1] = if_b.rsp_data;
      mpa[0]  = maddr_a;  mpa[1] = maddr_b;
      mpd[0]  = mdata_a;  mpd[1] = mdata_b;
      mwe[0]  = mwe_a;    mwe[1] = mwe_b;
   end

   // ---------------- memory device model ----------------
   logic [15:0] mem [2][65536];
   logic [15:0] dly [2][4];

   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         dly[u][0] <= mem[u][mpa[u]];
         for (int k = 1; k < 4; k++) dly[u][k] <= dly[u][k-1];
         if (mwe[u]) mem[u][mpa[u]] <= mpd[u];
      end
   end

   always_comb begin
      mdin_a = dly[0][0];
      mdin_b = dly[1][2];
   end

   // ---------------- scoreboard state ----------------
   typedef struct packed {
      logic [31:0] due;
      logic [15:0] a;
      logic [15:0] d;
      logic        w;
   } op_t;
   typedef struct packed {
      logic [31:0] due;
      logic [3:0]  ch;
      logic [15:0] d;
   } rs_t;

   op_t         op_q [2][$];
   rs_t         rs_q [2][$];
   logic [15:0] ref_mem [2][65536];
   int          mptr [2];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          done [2];

   task automatic check(input int u, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL lane%0d %s @cyc %0d: got %0h expected %0h", u, name, cyc, act, exp);
      end
   endtask

   // Reference arbitration: first valid channel scanning from the start point
   function automatic int exp_gnt(input int u);
      int n;
      int start;
      n     = nch(u);
      start = is_rr(u) ? mptr[u] : 0;
      for (int k = 0; k < n; k++) begin
         if (vld[u][(start + k) % n]) return (start + k) % n;
      end
      return -1;
   endfunction

   function automatic int oh2i(input logic [3:0] v);
      case (v)
         4'b0001: return 0;
         4'b0010: return 1;
         4'b0100: return 2;
         4'b1000: return 3;
         4'b0000: return -1;
         default: return 9;
      endcase
   endfunction

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem[0][a] = init_val(a);  mem[1][a] = init_val(a);
         ref_mem[0][a] = init_val(a);  ref_mem[1][a] = init_val(a);
      end
   end

   // Reference model: on each accepted request, queue the expected memory op and response
   always @(posedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (rst[u]) begin
            op_q[u].delete();
            rs_q[u].delete();
            mptr[u] = 0;
         end else begin
            int  g;
            op_t op;
            rs_t rs;
            g = exp_gnt(u);
            if (g >= 0) begin
               op = '{due: 32'(cyc + 1), a: addr[u][g], d: wdat[u][g], w: wr[u][g]};
               op_q[u].push_back(op);
               if (wr[u][g]) begin
                  ref_mem[u][addr[u][g]] = wdat[u][g];
               end else begin
                  rs = '{due: 32'(cyc + 2 + lat(u)), ch: 4'(g), d: ref_mem[u][addr[u][g]]};
                  rs_q[u].push_back(rs);
               end
               if (is_rr(u)) mptr[u] = (g + 1) % nch(u);
            end
         end
      end
      cyc = cyc + 1;
   end

   // ---------------- monitor ----------------
   bit          armed [2];
   logic [15:0] hold_a [2], hold_d [2], hold_r [2];
   logic [3:0]  pend [2];
   logic [32:0] prev_req [2][4];

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (armed[u]) begin
            int   g;
            logic [3:0] eg;
            op_t  op;
            rs_t  rs;
            g  = exp_gnt(u);
            eg = (g < 0) ? 4'b0000 : (4'b0001 << g);
            check(u, "req_ready", 64'(rdy[u]), 64'(eg));

            for (int c = 0; c < nch(u); c++) begin
               if (pend[u][c] && vld[u][c])
                  check(u, "req_hold", 64'({wr[u][c], addr[u][c], wdat[u][c]}), 64'(prev_req[u][c]));
            end

            if (op_q[u].size() > 0 && int'(op_q[u][0].due) == cyc) begin
               op = op_q[u].pop_front();
               check(u, "mem_addr", 64'(mpa[u]), 64'(op.a));
               check(u, "mem_data", 64'(mpd[u]), 64'(op.d));
               check(u, "mem_we",   64'(mwe[u]), 64'(op.w));
               hold_a[u] = op.a;
               hold_d[u] = op.d;
            end else begin
               check(u, "idle_we",   64'(mwe[u]), 64'(0));
               check(u, "idle_addr", 64'(mpa[u]), 64'(hold_a[u]));
               check(u, "idle_data", 64'(mpd[u]), 64'(hold_d[u]));
            end

            if (rs_q[u].size() > 0 && int'(rs_q[u][0].due) == cyc) begin
               rs = rs_q[u].pop_front();
               check(u, "rsp_valid", 64'(rspv[u]), 64'(4'b0001 << rs.ch));
               check(u, "rsp_data",  64'(rspd[u]), 64'(rs.d));
               hold_r[u] = rs.d;
            end else begin
               check(u, "rsp_idle",  64'(rspv[u]), 64'(0));
               check(u, "rsp_hold",  64'(rspd[u]), 64'(hold_r[u]));
            end
         end

         for (int c = 0; c < 4; c++) prev_req[u][c] = {wr[u][c], addr[u][c], wdat[u][c]};
         pend[u] = vld[u] & ~rdy[u];
         if (rst[u]) begin
            armed[u]  = 1'b1;
            hold_a[u] = '0;
            hold_d[u] = '0;
            hold_r[u] = '0;
            pend[u]   = '0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear(input int u);
      vld[u] = '0;
      wr[u]  = '0;
   endtask

   task automatic set_ch(input int u, input int c, input logic w, input logic [15:0] a, input logic [15:0] d);
      vld[u][c]  = 1'b1;
      wr[u][c]   = w;
      addr[u][c] = a;
      wdat[u][c] = d;
   endtask

   task automatic run_random(input int u, input int n);
      logic [3:0] acc;
      logic [3:0] keep;
      keep = '0;
      for (int k = 0; k < n; k++) begin
         for (int c = 0; c < nch(u); c++) begin
            if (!keep[c]) begin
               vld[u][c]  = ($urandom_range(0, 99) < 60);
               wr[u][c]   = ($urandom_range(0, 2) == 0);
               addr[u][c] = 16'($urandom_range(0, 31));
               wdat[u][c] = 16'($urandom);
            end
         end
         @(negedge clk);
         acc = vld[u] & rdy[u];
         tick();
         keep = vld[u] & ~acc;
      end
      clear(u);
   endtask

   // ---------------- lane 0: fixed priority, 2 channels, latency 1 ----------------
   initial begin
      clear(0);
      for (int c = 0; c < 4; c++) begin addr[0][c] = '0; wdat[0][c] = '0; end
      repeat (3) tick();
      rst[0] = 1'b0;
      tick();

      // Both channels read continuously: channel 0 always wins
      set_ch(0, 0, 1'b0, 16'h0010, 16'h0000);
      set_ch(0, 1, 1'b0, 16'h0020, 16'h0000);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check(0, "fixed_prio", 64'(rdy[0]), 64'(4'b0001));
         tick();
      end
      clear(0);
      repeat (4) tick();

      // Write on ch1, then read-after-write on ch0
      set_ch(0, 1, 1'b1, 16'h0042, 16'hBEEF);
      tick();
      clear(0);
      set_ch(0, 0, 1'b0, 16'h0042, 16'h0000);
      @(negedge clk);
      check(0, "raw_we",   64'(mwe[0]), 64'(1));
      check(0, "raw_addr", 64'(mpa[0]), 64'(16'h0042));
      check(0, "raw_data", 64'(mpd[0]), 64'(16'hBEEF));
      tick();
      clear(0);
      repeat (2) tick();
      @(negedge clk);
      check(0, "raw_rsp_valid", 64'(rspv[0]), 64'(4'b0001));
      check(0, "raw_rsp_data",  64'(rspd[0]), 64'(16'hBEEF));
      tick();

      // Ten idle cycles: nothing granted, address holds
      repeat (10) tick();
      @(negedge clk);
      check(0, "idle_ready", 64'(rdy[0]),  64'(0));
      check(0, "idle_hold",  64'(mpa[0]), 64'(16'h0042));
      tick();

      run_random(0, 300);
      done[0] = 1'b1;
   end

   // ---------------- lane 1: round-robin, 4 channels, latency 3 ----------------
   initial begin
      int exp_seq [10];
      int seq [$];
      exp_seq = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3};
      clear(1);
      for (int c = 0; c < 4; c++) begin addr[1][c] = '0; wdat[1][c] = '0; end
      repeat (3) tick();
      rst[1] = 1'b0;
      tick();

      // All four request continuously; ch2 drops out after one full rotation
      for (int c = 0; c < 4; c++) set_ch(1, c, 1'b0, 16'(16'h0100 + c), 16'h0000);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         seq.push_back(oh2i(rdy[1]));
         tick();
         if (k == 3) vld[1][2] = 1'b0;
      end
      clear(1);
      for (int k = 0; k < 10; k++) check(1, "rr_seq", 64'(seq[k]), 64'(exp_seq[k]));
      repeat (6) tick();

      // Four back-to-back reads alternating ch0/ch1
      for (int k = 0; k < 4; k++) begin
         clear(1);
         set_ch(1, k % 2, 1'b0, 16'(16'h0200 + k), 16'h0000);
         tick();
      end
      clear(1);
      tick();
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check(1, "b2b_rsp", 64'(rspv[1]), 64'((j % 2 == 0) ? 4'b0001 : 4'b0010));
         tick();
      end
      repeat (3) tick();

      // Two reads in flight, then reset: they must never respond
      set_ch(1, 1, 1'b0, 16'h0300, 16'h0000);
      tick();
      clear(1);
      set_ch(1, 2, 1'b0, 16'h0301, 16'h0000);
      tick();
      clear(1);
      rst[1] = 1'b1;
      tick();
      rst[1] = 1'b0;
      for (int c = 0; c < 4; c++) set_ch(1, c, 1'b0, 16'(16'h0310 + c), 16'h0000);
      @(negedge clk);
      check(1, "rst_first_grant", 64'(rdy[1]),  64'(4'b0001));
      check(1, "rst_addr",        64'(mpa[1]),  64'(0));
      check(1, "rst_data",        64'(mpd[1]),  64'(0));
      check(1, "rst_we",          64'(mwe[1]),  64'(0));
      check(1, "rst_rsp_valid",   64'(rspv[1]), 64'(0));
      check(1, "rst_rsp_data",    64'(rspd[1]), 64'(0));
      tick();
      clear(1);

      // Ten idle cycles: address holds the last issued request
      repeat (10) tick();
      @(negedge clk);
      check(1, "idle_ready", 64'(rdy[1]),  64'(0));
      check(1, "idle_hold",  64'(mpa[1]), 64'(16'h0310));
      tick();

      run_random(1, 300);
      done[1] = 1'b1;
   end

   // ---------------- final report ----------------
   initial begin
      int budget;
      budget = 0;
      while (!(done[0] && done[1]) && budget < 5000) begin
         @(posedge clk);
         budget++;
      end
      check(0, "lanes_finished", 64'(done[0] && done[1]), 64'(1));
      repeat (10) @(posedge clk);
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         check(u, "op_q_drained",  64'(op_q[u].size()), 64'(0));
         check(u, "rsp_q_drained", 64'(rs_q[u].size()), 64'(0));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
